// File: rtl/i2c_core_if.sv
// rtl/i2c_core_if.sv - controller request/response bus for i2c_core
interface i2c_core_if;
  logic       data_valid;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       core_busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_err;

  modport master (
    output data_valid, rw, slave_addr, reg_addr, reg_data,
    input  core_busy, rd_data, rd_valid, ack_err
  );

  modport slave (
    input  data_valid, rw, slave_addr, reg_addr, reg_data,
    output core_busy, rd_data, rd_valid, ack_err
  );
endinterface

// File: rtl/i2c_core.sv
// rtl/i2c_core.sv - I2C master for single-register write/read transfers
// Optional macro I2C_CORE_ACK_CHECK_EN: abort to STOP on a slave NACK and flag ack_err.
module i2c_core #(
  parameter int CLK_DIV = 125
) (
  input  logic      clk,
  input  logic      rst,
  i2c_core_if.slave bus,
  output logic      scl_oe,
  output logic      sda_oe,
  input  logic      sda_in
);

  localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, DATA, ACK_D,
    RSTART, ADDR_R, ACK_A2, READ, MNACK, STOP
  } state_t;

  state_t        state;
  logic [QW-1:0] q_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic          rw_q;
  logic [6:0]    sa_q;
  logic [7:0]    ra_q;
  logic [7:0]    wd_q;
  logic [7:0]    rx_sh;
  logic [7:0]    rd_data_q;
  logic          busy_q;
  logic          rd_valid_q;
  logic          ack_err_q;
  logic [7:0]    tx_byte;
  logic          q_end;
  logic          bit_end;
  logic          sample;
  logic          nack_stop;
  logic          scl_nxt;
  logic          sda_nxt;

  assign q_end   = (q_cnt == Q_LAST);
  assign sample  = q_end && (phase == 2'd2);
  assign bit_end = q_end && (phase == 2'd3);

`ifdef I2C_CORE_ACK_CHECK_EN
  assign nack_stop = ack_err_q;
`else
  assign nack_stop = 1'b0;
`endif

  assign bus.core_busy = busy_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ack_err   = ack_err_q;

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ADDR_W:  tx_byte = {sa_q, 1'b0};
      REG:     tx_byte = ra_q;
      DATA:    tx_byte = wd_q;
      ADDR_R:  tx_byte = {sa_q, 1'b1};
      default: tx_byte = 8'h00;
    endcase
  end

  // START keeps SCL released for the whole bit so SDA can fall with SCL high;
  // RSTART/STOP move SDA in phase 3 while SCL is high.
  always_comb begin
    scl_nxt = ~phase[1];
    sda_nxt = 1'b0;
    case (state)
      IDLE:                      scl_nxt = 1'b0;
      START: begin
        scl_nxt = 1'b0;
        sda_nxt = phase[1];
      end
      ADDR_W, REG, DATA, ADDR_R: sda_nxt = ~tx_byte[bit_cnt];
      RSTART:                    sda_nxt = (phase == 2'd3);
      STOP:                      sda_nxt = (phase != 2'd3);
      default:                   sda_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q_cnt      <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      rw_q       <= 1'b0;
      sa_q       <= '0;
      ra_q       <= '0;
      wd_q       <= '0;
      rx_sh      <= '0;
      rd_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      scl_oe     <= scl_nxt;
      sda_oe     <= sda_nxt;
      rd_valid_q <= 1'b0;
      if (state == IDLE) begin
        q_cnt <= '0;
        phase <= '0;
        if (bus.data_valid && !busy_q) begin
          rw_q      <= bus.rw;
          sa_q      <= bus.slave_addr;
          ra_q      <= bus.reg_addr;
          wd_q      <= bus.reg_data;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
          state     <= START;
        end
      end else begin
        q_cnt <= q_end ? '0 : q_cnt + 1'b1;
        if (q_end) phase <= phase + 2'd1;
        if (sample) begin
          if (state == READ) rx_sh <= {rx_sh[6:0], sda_in};
`ifdef I2C_CORE_ACK_CHECK_EN
          if ((state == ACK_A || state == ACK_R || state == ACK_D || state == ACK_A2) && sda_in)
            ack_err_q <= 1'b1;
`endif
        end
        if (bit_end) begin
          bit_cnt <= 3'd7;
          case (state)
            START:  state <= ADDR_W;
            ADDR_W: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) state <= ACK_A;
            end
            ACK_A:  state <= nack_stop ? STOP : REG;
            REG: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) state <= ACK_R;
            end
            ACK_R:  state <= nack_stop ? STOP : (rw_q ? RSTART : DATA);
            DATA: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) state <= ACK_D;
            end
            ACK_D:  state <= STOP;
            RSTART: state <= ADDR_R;
            ADDR_R: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) state <= ACK_A2;
            end
            ACK_A2: state <= nack_stop ? STOP : READ;
            READ: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                state      <= MNACK;
                rd_data_q  <= rx_sh;
                rd_valid_q <= 1'b1;
              end
            end
            MNACK:  state <= STOP;
            STOP: begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_core.sv
// tb/tb_i2c_core.sv - bus-level checks of i2c_core against a decoded-transaction model
module tb_i2c_core;
  localparam int DIV     = 5;
  localparam int SCL_PER = 4 * DIV;
`ifdef I2C_CORE_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif
  localparam int EV_S = 'h100;
  localparam int EV_P = 'h200;
  localparam int EV_A = 'h400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_oe;
  logic sda_oe;
  logic sda_in;
  logic slave_pull = 1'b0;

  i2c_core_if bus ();

  i2c_core #(.CLK_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .sda_in (sda_in)
  );

  assign sda_in = ~sda_oe & ~slave_pull;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_q[$];
  int         addr_byte[$];
  int         cyc = 0;
  int         rdv_cnt = 0;
  int         ack_seen = 0;
  int         last_period = 0;
  logic [7:0] rd_byte = 8'h00;
  bit         nack_first = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic log_event(input int e);
    if (exp_q.size() == 0) check("unexpected_bus_event", e, -1);
    else                   check("bus_event", e, exp_q.pop_front());
  endtask

  // Expected bus event sequence for one request, from the protocol rules
  function automatic void build_exp(input bit r, input logic [6:0] sa, input logic [7:0] ra,
                                    input logic [7:0] wd, input logic [7:0] rb, input bit nf);
    exp_q.push_back(EV_S);
    exp_q.push_back(int'({sa, 1'b0}));
    exp_q.push_back(EV_A | int'(nf));
    if (nf && ACK_CHK) begin
      exp_q.push_back(EV_P);
      return;
    end
    exp_q.push_back(int'(ra));
    exp_q.push_back(EV_A);
    if (!r) begin
      exp_q.push_back(int'(wd));
      exp_q.push_back(EV_A);
    end else begin
      exp_q.push_back(EV_S);
      exp_q.push_back(int'({sa, 1'b1}));
      exp_q.push_back(EV_A);
      exp_q.push_back(int'(rb));
      exp_q.push_back(EV_A | 1);
    end
    exp_q.push_back(EV_P);
  endfunction

  // Bus monitor and slave: decodes START/STOP/bytes/ACKs, ACKs bytes, returns rd_byte
  initial begin : monitor
    logic       pscl, psda, scl, sda, is_addr, slave_tx, next_tx;
    logic [7:0] sh;
    int         bitn, last_rise;
    bit         rise_ok;
    pscl = 1'b1; psda = 1'b1; is_addr = 1'b0; slave_tx = 1'b0; next_tx = 1'b0;
    sh = 8'h00; bitn = 0; last_rise = 0; rise_ok = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      scl = ~scl_oe;
      sda = sda_in;
      if (rst) begin
        pscl = scl; psda = sda; bitn = 0; is_addr = 1'b0; slave_tx = 1'b0;
        next_tx = 1'b0; rise_ok = 1'b0; slave_pull = 1'b0;
        continue;
      end
      if (scl_oe || sda_oe) check("busy_while_driving", int'(bus.core_busy), 1);
      if (bus.rd_valid) rdv_cnt++;
      if (pscl && scl && psda && !sda) begin
        log_event(EV_S);
        bitn = 0; is_addr = 1'b1; slave_tx = 1'b0; next_tx = 1'b0;
      end else if (pscl && scl && !psda && sda) begin
        log_event(EV_P);
        rise_ok = 1'b0; bitn = 0; is_addr = 1'b0; slave_tx = 1'b0;
      end else if (!pscl && scl) begin
        if (rise_ok) begin
          last_period = cyc - last_rise;
          check("scl_period", last_period, SCL_PER);
        end
        last_rise = cyc;
        rise_ok = 1'b1;
        if (bitn < 8) begin
          sh = {sh[6:0], sda};
          bitn++;
          if (bitn == 8) begin
            log_event(int'(sh));
            if (is_addr) addr_byte.push_back(int'(sh));
            next_tx = is_addr && sh[0] && !nack_first;
          end
        end else begin
          log_event(EV_A | int'(sda));
          ack_seen++;
          bitn = 0; is_addr = 1'b0; slave_tx = next_tx; next_tx = 1'b0;
        end
      end else if (pscl && !scl) begin
        if (bitn == 8)     slave_pull = slave_tx ? 1'b0 : !(nack_first && is_addr);
        else if (slave_tx) slave_pull = ~rd_byte[7-bitn];
        else               slave_pull = 1'b0;
      end
      pscl = scl;
      psda = sda;
    end
  end

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (bus.core_busy && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check({nm, "_done_in_budget"}, int'(t < 5000), 1);
  endtask

  task automatic drive_req(input bit r, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd);
    bus.rw = r; bus.slave_addr = sa; bus.reg_addr = ra; bus.reg_data = wd;
  endtask

  task automatic do_txn(input string nm, input bit r, input logic [6:0] sa, input logic [7:0] ra,
                        input logic [7:0] wd, input logic [7:0] rb, input bit nf, input bit poke);
    bit aborted;
    aborted = nf && ACK_CHK;
    build_exp(r, sa, ra, wd, rb, nf);
    rd_byte = rb; nack_first = nf; rdv_cnt = 0;
    @(posedge clk); #1;
    drive_req(r, sa, ra, wd);
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    check({nm, "_busy_after_accept"}, int'(bus.core_busy), 1);
    check({nm, "_ack_err_cleared"}, int'(bus.ack_err), 0);
    if (poke) begin
      repeat (100) @(posedge clk);
      #1;
      drive_req(~r, 7'h55, 8'hC3, 8'h99);
      bus.data_valid = 1'b1;
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
    end
    wait_idle(nm);
    check({nm, "_events_left"}, exp_q.size(), 0);
    check({nm, "_ack_err"}, int'(bus.ack_err), int'(aborted));
    check({nm, "_rd_valid_pulses"}, rdv_cnt, (r && !aborted) ? 1 : 0);
    exp_q.delete();
    nack_first = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t;
    bus.data_valid = 1'b0;
    drive_req(1'b0, 7'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_core_busy", int'(bus.core_busy), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_ack_err", int'(bus.ack_err), 0);
    check("rst_rd_data", int'(bus.rd_data), 0);
    rst = 1'b0;

    // Write, with an extra request strobed while busy
    addr_byte.delete();
    do_txn("write", 1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 1'b0, 1'b1);
    check("write_addr_literal", (addr_byte.size() > 0) ? addr_byte[0] : -1, 'h3A);
    check("scl_period_literal", last_period, 20);
    repeat (200) @(posedge clk);
    #1;
    check("no_second_txn", int'(bus.core_busy), 0);

    // Read
    addr_byte.delete();
    do_txn("read", 1'b1, 7'h1D, 8'h32, 8'h00, 8'hA5, 1'b0, 1'b0);
    check("read_rd_data", int'(bus.rd_data), 'hA5);
    check("read_addr_cnt", addr_byte.size(), 2);
    if (addr_byte.size() == 2) check("read_addr_r_literal", addr_byte[1], 'h3B);

    // NACK on the address byte
    do_txn("nack_addr", 1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 1'b1, 1'b0);

    // Reset during REG byte
    build_exp(1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 1'b0);
    ack_seen = 0;
    @(posedge clk); #1;
    drive_req(1'b0, 7'h1D, 8'h2D, 8'h08);
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    t = 0;
    while (ack_seen == 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_mid_reached_reg", int'(t < 5000), 1);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_scl_oe", int'(scl_oe), 0);
    check("rst_mid_sda_oe", int'(sda_oe), 0);
    check("rst_mid_core_busy", int'(bus.core_busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn("after_rst", 1'b0, 7'h1D, 8'h2D, 8'h08, 8'h00, 1'b0, 1'b0);

    // Back-to-back with data_valid held high
    build_exp(1'b0, 7'h50, 8'h01, 8'hFE, 8'h00, 1'b0);
    build_exp(1'b0, 7'h50, 8'h01, 8'hFE, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive_req(1'b0, 7'h50, 8'h01, 8'hFE);
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_accept", int'(bus.core_busy), 1);
    wait_idle("b2b_first");
    @(posedge clk); #1;
    check("b2b_gap_one_cycle", int'(bus.core_busy), 1);
    bus.data_valid = 1'b0;
    wait_idle("b2b_second");
    check("b2b_events_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (50) @(posedge clk);
    #1;
    check("b2b_no_third", int'(bus.core_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_core.md
I2C_CORE -- requirements
Module: i2c_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, clk cycles per quarter SCL bit period (50 MHz / (4*125) = 100 kHz).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset: one clock, reset is synchronous and active-high.
REQ-004 SHALL have port data_valid  input  1  one-cycle request strobe from the controller.
REQ-005 SHALL have port rw  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have port slave_addr  input  7  7-bit device address.
REQ-007 SHALL have port reg_addr  input  8  target register address.
REQ-008 SHALL have port reg_data  input  8  write payload; ignored when rw=1.
REQ-009 SHALL have port core_busy  output  1  high from acceptance until the STOP completes.
REQ-010 SHALL have port rd_data  output  8  last byte read from the slave.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse when rd_data updates.
REQ-012 SHALL have port ack_err  output  1  sticky NACK flag, cleared on the next accepted request.
REQ-013 SHALL have ports scl_oe and sda_oe  output  1 each  open-drain drive: 1 pulls the line low, 0 releases it.
REQ-014 SHALL have port sda_in  input  1  sampled SDA line level.

Function
REQ-015 SHALL accept a request only when data_valid=1 and core_busy=0; it SHALL latch rw, slave_addr, reg_addr and reg_data on that edge and assert core_busy on the next cycle.
REQ-016 SHALL ignore data_valid while core_busy=1.
REQ-017 SHALL use a quarter counter 0..CLK_DIV-1 and a phase 0..3 per bit: SCL is low in phases 0-1 and high in phases 2-3; SDA changes only at phase 0 entry; SDA is sampled on the last clk of phase 2.
REQ-018 SHALL implement the FSM IDLE -> START -> ADDR_W -> ACK_A -> REG -> ACK_R, then branch.
REQ-019 For rw=0, the branch SHALL be DATA -> ACK_D -> STOP.
REQ-020 For rw=1, the branch SHALL be RSTART -> ADDR_R -> ACK_A2 -> READ -> MNACK -> STOP.
REQ-021 START and RSTART SHALL drive SDA high-to-low while SCL is high; STOP SHALL drive SDA low-to-high while SCL is high and then return to IDLE.
REQ-022 Bytes SHALL be sent MSB first: ADDR_W = {slave_addr,0}, ADDR_R = {slave_addr,1}; a 3-bit bit counter SHALL count down 7..0.
REQ-023 READ SHALL shift sda_in into an 8-bit register MSB first; MNACK SHALL release SDA (NACK); rd_data and a one-cycle rd_valid SHALL be updated at MNACK entry.
REQ-024 core_busy SHALL deassert in the cycle after STOP completes; a new request may be accepted in that same cycle.
REQ-025 SHALL release SCL and SDA (oe=0) in IDLE.

Reset
REQ-026 While rst=1: state=IDLE, scl_oe=0, sda_oe=0, core_busy=0, rd_valid=0, ack_err=0, rd_data=8'h00, all counters 0.
REQ-027 rst asserted mid-transaction SHALL abort without generating a STOP; the bus SHALL be released on the next edge.

Configuration
REQ-028 Macro I2C_CORE_ACK_CHECK_EN defined: a high sda_in sampled in any ACK_* state SHALL set ack_err and jump to STOP, skipping the remaining bytes and rd_valid.
REQ-029 Macro I2C_CORE_ACK_CHECK_EN undefined: ACK bits SHALL be clocked but ignored, and ack_err SHALL be tied to 0.

Verification
REQ-030 Write: rw=0, 0x1D/0x2D/0x08 with slave ACKing -> SDA bytes 0x3A, 0x2D, 0x08; STOP; ack_err=0; core_busy high throughout, then low.
REQ-031 Read: rw=1, 0x1D/0x32, slave returns 0xA5 -> 0x3A, 0x32, Sr, 0x3B; rd_data=0xA5 with a single rd_valid pulse; master NACK then STOP.
REQ-032 NACK on the address byte with the macro defined -> ack_err=1, STOP after the 9th SCL, no REG byte; without the macro -> full transfer, ack_err=0.
REQ-033 data_valid pulsed during a busy write -> ignored; only one transaction appears on the bus.
REQ-034 rst asserted during the REG byte -> scl_oe=sda_oe=0 and core_busy=0 after one edge; the next request produces a clean START.
REQ-035 Back-to-back: data_valid held high -> second START begins in the cycle after core_busy falls; SCL period = 4*CLK_DIV clk (500 at default).
